// File: rtl/rv_operand_fetch.sv
// rv_operand_fetch
//   Operand-fetch stage. Owns the integer register file (x0 reads as zero),
//   pulls rs1/rs2 out of the decoded instruction, reads both operands with a
//   write-first bypass from the writeback port, and registers the result
//   into a valid/ready stage that feeds execute.
//
// Parameters
//   XLEN   register width
//   NREGS  architectural register count, 16 (RV32E-style) or 32
//   AW     register address width, derived from NREGS
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   flush                    drop the held instruction, accept nothing this cycle
//   in_valid/in_ready        decode handshake, in_instr is the instruction word
//   wb_en/wb_addr/wb_data    register file write port
//   out_valid/out_ready      execute handshake
//   out_instr, out_rs1/2     registered instruction and source fields
//   out_rs1/2_data           registered operands
//   out_illegal_reg          a source field addresses a register >= NREGS
module rv_operand_fetch #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_rs1_data,
    output logic [XLEN-1:0] out_rs2_data,
    output logic            out_illegal_reg
);

    // NREGS is a power of two (16 or 32), so every wb_addr value is in range;
    // only the 5-bit instruction fields can exceed the register count.
    function automatic logic in_range(input logic [4:0] f);
        return (NREGS == 32) || !f[4];
    endfunction

    logic [XLEN-1:0] regs [NREGS];

    logic [4:0]      rs1, rs2;
    logic [AW-1:0]   rs1_idx, rs2_idx, held1_idx, held2_idx;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic            accept, illegal;
    logic            held1_hit, held2_hit;

    assign rs1       = in_instr[19:15];
    assign rs2       = in_instr[24:20];
    assign rs1_idx   = rs1[AW-1:0];
    assign rs2_idx   = rs2[AW-1:0];
    assign held1_idx = out_rs1[AW-1:0];
    assign held2_idx = out_rs2[AW-1:0];

    assign in_ready = !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign illegal  = !in_range(rs1) || !in_range(rs2);

    // Write-first read: a same-cycle writeback to the source wins over the array.
    always_comb begin
        rs1_data = '0;
        if (rs1 != 5'd0 && in_range(rs1)) begin
            if (wb_en && wb_addr == rs1_idx) rs1_data = wb_data;
            else                             rs1_data = regs[rs1_idx];
        end
    end

    always_comb begin
        rs2_data = '0;
        if (rs2 != 5'd0 && in_range(rs2)) begin
            if (wb_en && wb_addr == rs2_idx) rs2_data = wb_data;
            else                             rs2_data = regs[rs2_idx];
        end
    end

    // A stalled instruction must still see writebacks that land while it waits,
    // otherwise execute would consume stale operands.
    assign held1_hit = wb_en && out_rs1 != 5'd0 && in_range(out_rs1) && wb_addr == held1_idx;
    assign held2_hit = wb_en && out_rs2 != 5'd0 && in_range(out_rs2) && wb_addr == held2_idx;

    // Register file. Entry 0 is never written, so it stays zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wb_en && wb_addr != '0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid       <= 1'b0;
            out_instr       <= '0;
            out_rs1         <= '0;
            out_rs2         <= '0;
            out_rs1_data    <= '0;
            out_rs2_data    <= '0;
            out_illegal_reg <= 1'b0;
        end else if (accept) begin
            out_valid       <= 1'b1;
            out_instr       <= in_instr;
            out_rs1         <= rs1;
            out_rs2         <= rs2;
            out_rs1_data    <= rs1_data;
            out_rs2_data    <= rs2_data;
            out_illegal_reg <= illegal;
        end else begin
            if (flush || out_ready) out_valid <= 1'b0;
            if (out_valid && !out_ready) begin
                if (held1_hit) out_rs1_data <= wb_data;
                if (held2_hit) out_rs2_data <= wb_data;
            end
        end
    end

endmodule

// File: doc/rv_operand_fetch.md
Name: rv_operand_fetch

Overview:
- Parametrised successor to the combinational rs1/rs2 field extractor.
- Extracts rs1/rs2 from the decoded instruction and owns the integer register file (x0 hardwired to zero).
- Reads both operands with same-cycle writeback bypass.
- Registers the result into a valid/ready pipeline stage feeding execute; supports stall, flush and RV32E-style reduced register count.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; legal values are 16 or 32.
- AW, $clog2(NREGS), register address width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  kill the held stage and block acceptance this cycle.
- in_valid  input  1  decode presents an instruction.
- in_ready  output  1  stage can accept this cycle.
- in_instr  input  32  decoded instruction word.
- wb_en  input  1  writeback write enable.
- wb_addr  input  AW  writeback destination.
- wb_data  input  XLEN  writeback data.
- out_valid  output  1  held operands valid.
- out_ready  input  1  execute consumes this cycle.
- out_instr  output  32  registered instruction.
- out_rs1  output  5  registered instr[19:15].
- out_rs2  output  5  registered instr[24:20].
- out_rs1_data  output  XLEN  operand 1.
- out_rs2_data  output  XLEN  operand 2.
- out_illegal_reg  output  1  rs1 or rs2 field is >= NREGS.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). Reset has priority over every other input.
- On rst: all NREGS registers <= 0; out_valid, out_instr, out_rs1, out_rs2, out_rs1_data, out_rs2_data and out_illegal_reg <= 0.
- Register file:
  - Writes occur on the clk edge when wb_en=1, wb_addr!=0 and wb_addr<NREGS.
  - Writes to x0 or to an out-of-range address are ignored.
  - Writeback is independent of flush and stall.
- Read with bypass, per operand rsN:
  - field==0 or field>=NREGS -> 0.
  - Else wb_en && wb_addr==field -> wb_data (write-first).
  - Else stored register value.
- in_ready = !flush && (!out_valid || out_ready). It is combinational with no registered path from in_valid.
- Accept (in_valid && in_ready):
  - Next edge loads out_instr, out_rs1, out_rs2, the bypassed data and out_illegal_reg; out_valid <= 1.
  - Latency is 1 cycle.
- Consume without new accept (out_valid && out_ready && !accept): out_valid <= 0. Data outputs keep their last values.
- Hold (out_valid && !out_ready):
  - All outputs stable, with one exception: if wb_en and wb_addr equals a held nonzero, in-range rsN, out_rsN_data <= wb_data.
  - This keeps stalled operands coherent with later writebacks.
- Flush:
  - out_valid <= 0 next edge and in_ready=0, so nothing is captured that cycle.
  - Writeback in the same cycle still commits.
- Simultaneous consume+accept: new data loads and out_valid stays 1 (back-to-back throughput of one per cycle).
- out_illegal_reg is only meaningful when NREGS=16. It is constant 0 for NREGS=32.
- in_valid dropping while in_ready=0 is a protocol error upstream; the block does not check it.

Test Plan:
- Reset/basic read: rst 1 cycle, then wb x5<=0xDEADBEEF; next cycle in_instr=0x00500133 (add x2,x0,x5) -> out_valid=1 one cycle later, out_rs1=0, out_rs1_data=0, out_rs2=5, out_rs2_data=0xDEADBEEF.
- Bypass: same cycle as accept of instr with rs1=7, drive wb_en=1, wb_addr=7, wb_data=0x12345678 -> out_rs1_data=0x12345678. Separately, wb to x0 with 0xFFFFFFFF, then read x0 -> 0.
- Stall refresh: hold out_ready=0 with rs2=3 held and out_rs2_data=0xA; wb x3<=0xB -> out_rs2_data=0xB next cycle, in_ready=0, out_instr unchanged.
- Back-to-back: out_ready=1 and in_valid=1 for 4 consecutive instructions -> 4 consecutive out_valid cycles in order, no bubbles.
- Flush: out_valid=1 and in_valid=1 with flush=1 -> in_ready=0, out_valid=0 next cycle, pending instruction not captured.
- NREGS=16: instr with rs1=17 -> out_illegal_reg=1, out_rs1_data=0. wb_addr=16 is ignored; a subsequent read of x0 still returns 0.
